block_sync_66: RTL and testbench
================================

BLOCK_SYNC_66 -- requirements
Module: block_sync_66

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64: consecutive valid headers needed to declare lock.
REQ-002 SHALL have parameter BAD_LIMIT, default 16: invalid headers within one window that cause loss of lock.
REQ-003 SHALL have parameter WINDOW, default 64: valid input words per monitoring window while locked.
REQ-004 SHALL have parameter SLIP_WAIT, default 4: valid input words ignored after each slip pulse.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port arst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port din  input  66  word from the 32-to-66 gearbox; sync header in [1:0], payload in [65:2].
REQ-008 SHALL have port din_valid  input  1  din qualifier.
REQ-009 SHALL have port slip  output  1  one-cycle pulse to the gearbox slip_to_frame input.
REQ-010 SHALL have port word_lock  output  1  block lock achieved.
REQ-011 SHALL have port dout  output  64  payload, din[65:2].
REQ-012 SHALL have port dout_hdr  output  2  header, din[1:0].
REQ-013 SHALL have port dout_valid  output  1  dout/dout_hdr qualifier.
REQ-014 SHALL have port bad_hdr_count  output  16  invalid-header statistic (see Configuration).

Function
REQ-015 SHALL treat header 2'b01 or 2'b10 as valid; 2'b00 and 2'b11 as invalid.
REQ-016 SHALL evaluate headers only on cycles with din_valid=1; other cycles change no counters.
REQ-017 SHALL implement states HUNT, SLIP_WAIT, LOCKED.
REQ-018 HUNT: valid header increments good counter; good counter reaching LOCK_CNT -> LOCKED, word_lock=1 next cycle, counters cleared.
REQ-019 HUNT: invalid header -> slip=1 for exactly one cycle, good counter cleared, -> SLIP_WAIT.
REQ-020 SLIP_WAIT: count SLIP_WAIT valid words ignoring headers, then -> HUNT with counters cleared.
REQ-021 LOCKED: each valid word increments window counter; each invalid header increments bad counter.
REQ-022 LOCKED: bad counter reaching BAD_LIMIT -> word_lock=0, slip pulse, -> SLIP_WAIT, same cycle priority over window end.
REQ-023 LOCKED: window counter reaching WINDOW with bad < BAD_LIMIT -> both counters cleared, stay LOCKED; the last word of a window counts toward that window.
REQ-024 SHALL register dout/dout_hdr from din with one-cycle latency, updated on every valid input.
REQ-025 SHALL drive dout_valid = registered (din_valid AND word_lock as of the input cycle); no output during HUNT/SLIP_WAIT.
REQ-026 slip SHALL never assert on two consecutive cycles.
REQ-027 Counters SHALL be sized from parameters via clog2 and never wrap.

Reset
REQ-028 arst SHALL asynchronously force HUNT, all counters 0, slip=0, word_lock=0, dout_valid=0, dout=0, dout_hdr=0, bad_hdr_count=0.
REQ-029 Reset asserted mid-window or mid-SLIP_WAIT SHALL abandon that operation; after release, operation restarts from HUNT.

Configuration
REQ-030 Macro BLOCK_SYNC_66_ERRCNT_EN defined: bad_hdr_count increments on every invalid header while word_lock=1, saturating at 16'hffff, cleared only by arst.
REQ-031 Macro BLOCK_SYNC_66_ERRCNT_EN undefined: bad_hdr_count tied to 0, no counter logic generated; all other behaviour identical.

Verification
REQ-032 Always-valid stream of 64 words with header 2'b01 after reset -> word_lock=1 on the cycle after the 64th word, no slip.
REQ-033 Gearbox loopback with misaligned start -> slip pulses, each followed by >=4 ignored words, until word_lock=1; recovered payload first byte in {"b","y","m","t","c","g","H",8'hff}.
REQ-034 Locked, inject 15 headers 2'b11 within one 64-word window -> word_lock stays 1; with macro, bad_hdr_count=15.
REQ-035 Locked, inject 16 headers 2'b00 within one window -> slip pulse and word_lock=0 on the cycle after the 16th; dout_valid deasserts.
REQ-036 din_valid toggling 1/0 every cycle -> lock after 64 valid words (127 cycles); dout_valid only follows valid inputs.
REQ-037 arst pulsed while locked -> all outputs 0 immediately; relock after 64 further valid words.

Source files
------------

// File: rtl/block_sync_66.sv
`default_nettype none
// ============================================================================
// Module      : block_sync_66
// Description : 64b/66b block synchroniser. Hunts for sync-header lock,
//               pulses slip to the gearbox when framing is wrong, and
//               monitors header quality per window once locked.
// Options     : define BLOCK_SYNC_66_ERRCNT_EN to build the bad_hdr_count
//               statistic; otherwise bad_hdr_count is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module block_sync_66 #(
   parameter int LOCK_CNT  = 64,
   parameter int BAD_LIMIT = 16,
   parameter int WINDOW    = 64,
   parameter int SLIP_WAIT = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [65:0] din,
   input  logic        din_valid,
   output logic        slip,
   output logic        word_lock,
   output logic [63:0] dout,
   output logic [1:0]  dout_hdr,
   output logic        dout_valid,
   output logic [15:0] bad_hdr_count
);

   // Each counter is wide enough to hold its terminal value, so none can wrap.
   localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int c_WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int c_WIN_W  = $clog2(WINDOW + 1);
   localparam int c_BAD_W  = $clog2(BAD_LIMIT + 1);

   localparam logic [c_GOOD_W-1:0] c_LOCK_MAX = c_GOOD_W'(LOCK_CNT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(SLIP_WAIT);
   localparam logic [c_WIN_W-1:0]  c_WIN_MAX  = c_WIN_W'(WINDOW);
   localparam logic [c_BAD_W-1:0]  c_BAD_MAX  = c_BAD_W'(BAD_LIMIT);

   typedef enum logic [1:0] {
      ST_HUNT      = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   state_t              r_state,    w_state_nxt;
   logic [c_GOOD_W-1:0] r_good_cnt, w_good_nxt;
   logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
   logic [c_WIN_W-1:0]  r_win_cnt,  w_win_nxt;
   logic [c_BAD_W-1:0]  r_bad_cnt,  w_bad_nxt;
   logic                r_slip,     w_slip_nxt;
   logic [63:0]         r_dout;
   logic [1:0]          r_hdr;
   logic                r_dout_valid;

   logic                w_hdr_ok;
   logic [c_GOOD_W-1:0] w_good_inc;
   logic [c_WAIT_W-1:0] w_wait_inc;
   logic [c_WIN_W-1:0]  w_win_inc;
   logic [c_BAD_W-1:0]  w_bad_inc;

   // Only 01 and 10 are legal sync headers.
   assign w_hdr_ok   = din[1] ^ din[0];
   assign w_good_inc = r_good_cnt + c_GOOD_W'(1);
   assign w_wait_inc = r_wait_cnt + c_WAIT_W'(1);
   assign w_win_inc  = r_win_cnt  + c_WIN_W'(1);
   assign w_bad_inc  = r_bad_cnt  + c_BAD_W'(1);

   // State and counter registers.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state    <= ST_HUNT;
         r_good_cnt <= '0;
         r_wait_cnt <= '0;
         r_win_cnt  <= '0;
         r_bad_cnt  <= '0;
         r_slip     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_win_cnt  <= w_win_nxt;
         r_bad_cnt  <= w_bad_nxt;
         r_slip     <= w_slip_nxt;
      end
   end

   // Next-state logic; idle cycles (din_valid low) leave everything as is.
   // A slip is only ever requested on leaving HUNT or LOCKED, and the next
   // cycle is always in SLIP_WAIT, so two slips can never be back to back.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_wait_nxt  = r_wait_cnt;
      w_win_nxt   = r_win_cnt;
      w_bad_nxt   = r_bad_cnt;
      w_slip_nxt  = 1'b0;
      if (din_valid) begin
         case (r_state)
            ST_HUNT: begin
               if (!w_hdr_ok) begin
                  w_slip_nxt  = 1'b1;
                  w_good_nxt  = '0;
                  w_wait_nxt  = '0;
                  w_state_nxt = ST_SLIP_WAIT;
               end else if (w_good_inc == c_LOCK_MAX) begin
                  w_good_nxt  = '0;
                  w_win_nxt   = '0;
                  w_bad_nxt   = '0;
                  w_state_nxt = ST_LOCKED;
               end else begin
                  w_good_nxt  = w_good_inc;
               end
            end
            ST_SLIP_WAIT: begin
               if (w_wait_inc == c_WAIT_MAX) begin
                  w_wait_nxt  = '0;
                  w_good_nxt  = '0;
                  w_state_nxt = ST_HUNT;
               end else begin
                  w_wait_nxt  = w_wait_inc;
               end
            end
            ST_LOCKED: begin
               // Loss of lock wins over a coincident window end.
               if (!w_hdr_ok && (w_bad_inc == c_BAD_MAX)) begin
                  w_slip_nxt  = 1'b1;
                  w_win_nxt   = '0;
                  w_bad_nxt   = '0;
                  w_wait_nxt  = '0;
                  w_state_nxt = ST_SLIP_WAIT;
               end else if (w_win_inc == c_WIN_MAX) begin
                  w_win_nxt   = '0;
                  w_bad_nxt   = '0;
               end else begin
                  w_win_nxt   = w_win_inc;
                  if (!w_hdr_ok) begin
                     w_bad_nxt = w_bad_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_HUNT;
            end
         endcase
      end
   end

   // Output pipeline: data follows every valid word, qualifier only when locked.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_dout       <= '0;
         r_hdr        <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= din_valid & word_lock;
         if (din_valid) begin
            r_dout <= din[65:2];
            r_hdr  <= din[1:0];
         end
      end
   end

   assign word_lock  = (r_state == ST_LOCKED);
   assign slip       = r_slip;
   assign dout       = r_dout;
   assign dout_hdr   = r_hdr;
   assign dout_valid = r_dout_valid;

`ifdef BLOCK_SYNC_66_ERRCNT_EN
   logic [15:0] r_err_cnt;

   // Saturating count of invalid headers seen while locked.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_err_cnt <= '0;
      end else if (din_valid && word_lock && !w_hdr_ok && (r_err_cnt != 16'hffff)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign bad_hdr_count = r_err_cnt;
`else
   assign bad_hdr_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_sync_66.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_block_sync_66
// Description : Self-checking bench for block_sync_66: a behavioural model
//               checked every cycle plus directed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_block_sync_66;

   localparam int LOCK_CNT  = 64;
   localparam int BAD_LIMIT = 16;
   localparam int WINDOW    = 64;
   localparam int SLIP_WAIT = 4;
   localparam int M_HUNT    = 0;
   localparam int M_WAIT    = 1;
   localparam int M_LOCK    = 2;

   logic        clk       = 1'b0;
   logic        arst      = 1'b0;
   logic [65:0] din       = '0;
   logic        din_valid = 1'b0;
   logic        slip;
   logic        word_lock;
   logic [63:0] dout;
   logic [1:0]  dout_hdr;
   logic        dout_valid;
   logic [15:0] bad_hdr_count;

   block_sync_66 #(
      .LOCK_CNT  (LOCK_CNT),
      .BAD_LIMIT (BAD_LIMIT),
      .WINDOW    (WINDOW),
      .SLIP_WAIT (SLIP_WAIT)
   ) dut (
      .clk           (clk),
      .arst          (arst),
      .din           (din),
      .din_valid     (din_valid),
      .slip          (slip),
      .word_lock     (word_lock),
      .dout          (dout),
      .dout_hdr      (dout_hdr),
      .dout_valid    (dout_valid),
      .bad_hdr_count (bad_hdr_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode = M_HUNT;
   int          m_good = 0;
   int          m_wait = 0;
   int          m_win  = 0;
   int          m_bad  = 0;
   int          m_err  = 0;
   logic        e_slip = 1'b0;
   logic        e_dv   = 1'b0;
   logic [63:0] e_dout = '0;
   logic [1:0]  e_hdr  = '0;
   logic        hbad;

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         m_mode = M_HUNT; m_good = 0; m_wait = 0; m_win = 0; m_bad = 0; m_err = 0;
         e_slip = 1'b0; e_dv = 1'b0; e_dout = '0; e_hdr = '0;
      end else begin
         e_slip = 1'b0;
         e_dv   = din_valid && (m_mode == M_LOCK);
         if (din_valid) begin
            e_dout = din[65:2];
            e_hdr  = din[1:0];
            hbad   = (din[1] == din[0]);
            if (m_mode == M_LOCK && hbad && m_err < 65535) m_err++;
            if (m_mode == M_HUNT) begin
               if (hbad) begin
                  m_good = 0; e_slip = 1'b1; m_mode = M_WAIT; m_wait = 0;
               end else begin
                  m_good++;
                  if (m_good == LOCK_CNT) begin
                     m_mode = M_LOCK; m_good = 0; m_win = 0; m_bad = 0;
                  end
               end
            end else if (m_mode == M_WAIT) begin
               m_wait++;
               if (m_wait == SLIP_WAIT) begin
                  m_mode = M_HUNT; m_good = 0; m_wait = 0;
               end
            end else begin
               m_win++;
               if (hbad) m_bad++;
               if (m_bad == BAD_LIMIT) begin
                  e_slip = 1'b1; m_mode = M_WAIT; m_wait = 0;
               end else if (m_win == WINDOW) begin
                  m_win = 0; m_bad = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic prev_slip = 1'b0;

   always @(negedge clk) begin
      chk("word_lock",  64'(word_lock),  64'(m_mode == M_LOCK));
      chk("slip",       64'(slip),       64'(e_slip));
      chk("dout_valid", 64'(dout_valid), 64'(e_dv));
      chk("dout",       dout,            e_dout);
      chk("dout_hdr",   64'(dout_hdr),   64'(e_hdr));
`ifdef BLOCK_SYNC_66_ERRCNT_EN
      chk("bad_hdr_count", 64'(bad_hdr_count), 64'(m_err));
`else
      chk("bad_hdr_count", 64'(bad_hdr_count), 64'd0);
`endif
      chk("slip_consecutive", 64'(slip & prev_slip), 64'd0);
      prev_slip = slip;
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [63:0] pay(input int i);
      return 64'h0123_4567_89ab_cdef ^ 64'(i * 32'h9e37_79b9);
   endfunction

   task automatic drive(input logic [65:0] d, input logic v);
      @(posedge clk);
      #1;
      din       = d;
      din_valid = v;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 arst = 1'b1;
      @(posedge clk);
      #1 arst = 1'b0;
   endtask

   logic [7:0]  byte_set [8] = '{"b", "y", "m", "t", "c", "g", "H", 8'hff};
   logic [65:0] frames [0:1599];

   function automatic logic in_set(input logic [7:0] b);
      for (int j = 0; j < 8; j++) if (byte_set[j] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [65:0] gear_word(input int p0);
      logic [65:0] w;
      for (int b = 0; b < 66; b++) begin
         w[b] = frames[(p0 + b) / 66][(p0 + b) % 66];
      end
      return w;
   endfunction

   int pos;
   int n_slip;
   int got;

   initial begin
      for (int f = 0; f < 1600; f++) begin
         frames[f] = {32'($urandom()), 24'($urandom()), byte_set[f % 8], 2'b01};
      end

      // Reset state.
      #1 arst = 1'b1;
      #1;
      chk("rst_slip",      64'(slip),          64'd0);
      chk("rst_word_lock", 64'(word_lock),     64'd0);
      chk("rst_dout_valid",64'(dout_valid),    64'd0);
      chk("rst_dout",      dout,               64'd0);
      chk("rst_dout_hdr",  64'(dout_hdr),      64'd0);
      chk("rst_bad_cnt",   64'(bad_hdr_count), 64'd0);
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;

      // 64 good headers: lock on the cycle after the 64th, not before.
      for (int i = 0; i < 64; i++) begin
         drive({pay(i), 2'b01}, 1'b1);
         if (i == 63) chk("lock_after_63", 64'(word_lock), 64'd0);
      end
      drive('0, 1'b0);
      chk("lock_after_64", 64'(word_lock), 64'd1);
      chk("no_slip_lock",  64'(slip),      64'd0);
      chk("dv_last_hunt",  64'(dout_valid),64'd0);

      // One window with 15 bad headers: lock held.
      for (int i = 0; i < 64; i++) begin
         drive({pay(100 + i), ((i % 4 == 0) && (i < 60)) ? 2'b11 : 2'b01}, 1'b1);
      end
      drive('0, 1'b0);
      chk("lock_15_bad", 64'(word_lock), 64'd1);
`ifdef BLOCK_SYNC_66_ERRCNT_EN
      chk("errcnt_15", 64'(bad_hdr_count), 64'd15);
`endif

      // 16 bad headers in the next window: slip and unlock after the 16th.
      for (int i = 0; i < 16; i++) begin
         drive({pay(200 + i), 2'b00}, 1'b1);
         if (i == 15) chk("lock_at_15th", 64'(word_lock), 64'd1);
      end
      drive('0, 1'b0);
      chk("slip_16_bad",  64'(slip),       64'd1);
      chk("unlock_16",    64'(word_lock),  64'd0);
      chk("dv_16th_word", 64'(dout_valid), 64'd1);
      drive('0, 1'b0);
      chk("slip_one_cyc", 64'(slip),       64'd0);
      chk("dv_deassert",  64'(dout_valid), 64'd0);

      // din_valid toggling: 64 valid words over 127 cycles.
      pulse_reset();
      for (int c = 0; c < 127; c++) begin
         drive({pay(300 + c), 2'b10}, (c % 2) == 0);
      end
      drive('0, 1'b0);
      chk("lock_toggle", 64'(word_lock), 64'd1);

      // Asynchronous reset while locked.
      @(posedge clk);
      #1 arst = 1'b1;
      #1;
      chk("arst_lock", 64'(word_lock),     64'd0);
      chk("arst_dout", dout,               64'd0);
      chk("arst_hdr",  64'(dout_hdr),      64'd0);
      chk("arst_dv",   64'(dout_valid),    64'd0);
      chk("arst_slip", 64'(slip),          64'd0);
      chk("arst_bad",  64'(bad_hdr_count), 64'd0);
      #1 arst = 1'b0;
      for (int i = 0; i < 64; i++) drive({pay(500 + i), 2'b01}, 1'b1);
      drive('0, 1'b0);
      chk("relock", 64'(word_lock), 64'd1);

      // Gearbox loopback from a misaligned bit offset.
      pulse_reset();
      pos = 23; n_slip = 0; got = 0;
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk);
         #1;
         if (slip) begin
            n_slip++;
            pos++;
         end
         if (word_lock) got++;
         if (got > 4) break;
         din       = gear_word(pos);
         din_valid = 1'b1;
         pos       = pos + 66;
      end
      chk("gear_lock",    64'(got > 4),      64'd1);
      chk("gear_slipped", 64'(n_slip > 0),   64'd1);
      chk("gear_aligned", 64'(pos % 66),     64'd0);
      chk("gear_dv",      64'(dout_valid),   64'd1);
      chk("gear_byte",    64'(in_set(dout[7:0])), 64'd1);
      chk("gear_hdr",     64'(dout_hdr),     64'd1);
      drive('0, 1'b0);
      drive('0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
